// File: rtl/key_event_pkg.sv
// Shared constants for the keyboard event path: scan codes, event word bit
// positions and the prefix state encoding.
package key_event_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] SC_IGN_00 = 8'h00;
  localparam logic [7:0] SC_IGN_AA = 8'hAA;
  localparam logic [7:0] SC_IGN_FA = 8'hFA;
  localparam logic [7:0] SC_IGN_FE = 8'hFE;
  localparam logic [7:0] SC_IGN_FF = 8'hFF;

  // Bytes swallowed after E1 (pause sequence is E1 plus seven more bytes).
  localparam logic [2:0] DROP_LEN = 3'd7;

  localparam int EV_BREAK = 15;
  localparam int EV_EXT   = 14;
  localparam int EV_SHIFT = 13;
  localparam int EV_CTRL  = 12;
  localparam int EV_ALT   = 11;
  localparam int EV_CAPS  = 10;
  localparam int EV_RAW   = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_DROP   = 3'd4
  } prefix_state_e;

  function automatic logic is_ignore(input logic [7:0] b);
    return b inside {SC_IGN_00, SC_IGN_AA, SC_IGN_FA, SC_IGN_FE, SC_IGN_FF};
  endfunction

  function automatic logic is_modifier(input logic [7:0] b);
    return b inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT, SC_CAPS};
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous event FIFO; a push into a full FIFO without a pop is dropped and
// flagged through a sticky overflow bit that an accepted pop clears.
module key_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  head_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              full, empty, do_pop, do_push, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty;
  // A simultaneous pop frees the slot first, so a full FIFO still accepts.
  assign do_push = push_i & (~full | do_pop);
  assign drop    = push_i & full & ~do_pop;

  // NOTE: storage has no reset; only pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)        overflow_q <= 1'b1;
      else if (do_pop) overflow_q <= 1'b0;
    end
  end

  assign head_o     = empty ? '0 : mem_q[rd_ptr_q];
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/key_event_queue.sv
// PS/2 scan byte to key event converter: prefix FSM, modifier tracking and
// a FIFO of packed 16-bit event words drained by the CPU.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_valid,
  input  logic [7:0]        scan_byte,
  input  logic [7:0]        scan_ascii,
  input  logic              ren,
  output logic [15:0]       data,
  output logic              ready,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  prefix_state_e state_q, state_d;
  logic [2:0]    drop_cnt_q, drop_cnt_d;
  logic          lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q;
  logic          key_done, is_break, is_ext, raw, push, fifo_empty;
  logic [15:0]   event_word;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    key_done   = 1'b0;
    is_break   = 1'b0;
    is_ext     = 1'b0;
    if (scan_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_byte == SC_E0) state_d = ST_EXT;
          else if (scan_byte == SC_F0) state_d = ST_BRK;
          else if (scan_byte == SC_E1) begin
            state_d    = ST_DROP;
            drop_cnt_d = DROP_LEN;
          end else if (!is_ignore(scan_byte)) key_done = 1'b1;
        end
        ST_EXT: begin
          if (scan_byte == SC_F0) state_d = ST_EXTBRK;
          else begin
            key_done = 1'b1;
            is_ext   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          key_done = 1'b1;
          is_break = 1'b1;
          is_ext   = (state_q == ST_EXTBRK);
          state_d  = ST_IDLE;
        end
        ST_DROP: begin
          drop_cnt_d = drop_cnt_q - 3'd1;
          if (drop_cnt_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign raw  = (scan_ascii == 8'h00);
  assign push = key_done & ~is_modifier(scan_byte);

  always_comb begin
    event_word           = '0;
    event_word[EV_BREAK] = is_break;
    event_word[EV_EXT]   = is_ext;
    event_word[EV_SHIFT] = lshift_q | rshift_q;
    event_word[EV_CTRL]  = lctrl_q | rctrl_q;
    event_word[EV_ALT]   = lalt_q | ralt_q;
    event_word[EV_CAPS]  = caps_q;
    event_word[EV_RAW]   = raw;
    event_word[7:0]      = raw ? scan_byte : scan_ascii;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drop_cnt_q <= '0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      lctrl_q    <= 1'b0;
      rctrl_q    <= 1'b0;
      lalt_q     <= 1'b0;
      ralt_q     <= 1'b0;
      caps_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      if (key_done) begin
        case (scan_byte)
          SC_LSHIFT: lshift_q <= ~is_break;
          SC_RSHIFT: rshift_q <= ~is_break;
          SC_CTRL:   if (is_ext) rctrl_q <= ~is_break; else lctrl_q <= ~is_break;
          SC_ALT:    if (is_ext) ralt_q  <= ~is_break; else lalt_q  <= ~is_break;
          SC_CAPS:   if (!is_break) caps_q <= ~caps_q;
          default:   ;
        endcase
      end
    end
  end

  key_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (16)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (event_word),
    .pop_i       (ren),
    .head_o      (data),
    .empty_o     (fifo_empty),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  assign ready = ~fifo_empty;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus random scan traffic,
// compared every cycle against a queue-based behavioural model.
module tb_key_event_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_valid, ren;
  logic [7:0]  scan_byte, scan_ascii;
  logic [15:0] data;
  logic        ready, overflow;
  logic [4:0]  count;

  key_event_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_valid (scan_valid),
    .scan_byte  (scan_byte),
    .scan_ascii (scan_ascii),
    .ren        (ren),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .count      (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: prefix flags, a countdown of bytes to swallow,
  // modifier flags and a queue of event words.
  bit          m_ext, m_brk, m_ovf;
  int          m_drop;
  bit          ls, rs, lc, rc, la, ra, caps;
  logic [15:0] mq[$];

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_drop = 0;
    ls = 0; rs = 0; lc = 0; rc = 0; la = 0; ra = 0; caps = 0;
    mq.delete();
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] b,
                                     input logic [7:0] a, input bit r);
    bit          have_key = 0, brk = 0, ext = 0, push = 0, popped, dropped = 0;
    logic [15:0] w = '0;
    if (v) begin
      if (m_drop > 0) m_drop--;
      else if (m_brk) begin have_key = 1; brk = 1; ext = m_ext; end
      else if (b == 8'hF0) m_brk = 1;
      else if (m_ext) begin have_key = 1; ext = 1; end
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hE1) m_drop = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) have_key = 1;
    end
    if (have_key) begin
      m_ext = 0;
      m_brk = 0;
      case (b)
        8'h12: ls = !brk;
        8'h59: rs = !brk;
        8'h14: if (ext) rc = !brk; else lc = !brk;
        8'h11: if (ext) ra = !brk; else la = !brk;
        8'h58: if (!brk) caps = !caps;
        default: begin
          push = 1;
          w = {brk, ext, ls | rs, lc | rc, la | ra, caps, (a == 8'h00), 1'b0,
               (a != 8'h00) ? a : b};
        end
      endcase
    end
    popped = r && (mq.size() > 0);
    if (popped) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (popped) m_ovf = 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".ready"}, 32'(ready), 32'(mq.size() != 0));
    check({tag, ".data"},  32'(data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
  endtask

  // Called at a negedge; drives one cycle, updates the model, checks at next negedge.
  task automatic step(input bit v, input logic [7:0] b, input logic [7:0] a, input bit r);
    scan_valid = v; scan_byte = b; scan_ascii = a; ren = r;
    @(posedge clk);
    model_step(v, b, a, r);
    @(negedge clk);
    scan_valid = 1'b0; ren = 1'b0;
    compare_all("step");
  endtask

  task automatic key(input logic [7:0] b, input logic [7:0] a);
    step(1'b1, b, a, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  // Reset pulse placed between edges, exercising the asynchronous path.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all("reset");
  endtask

  logic [7:0] specials [13] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'hE0, 8'hF0,
                                8'hE1, 8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

  initial begin
    rst = 1'b1; scan_valid = 1'b0; ren = 1'b0; scan_byte = '0; scan_ascii = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.count", 32'(count), 32'd0);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.data",  32'(data),  32'h0);
    check("rst.ovf",   32'(overflow), 32'd0);

    // Make then break
    key(8'h1C, 8'h61); key(8'hF0, 8'h00); key(8'h1C, 8'h61);
    check("mb.count", 32'(count), 32'd2);
    check("mb.head0", 32'(data), 32'h0061);
    pop();
    check("mb.head1", 32'(data), 32'h8061);
    pop();
    check("mb.ready", 32'(ready), 32'd0);

    // Shift and caps lock
    key(8'h12, 8'h00); key(8'h1C, 8'h61); key(8'hF0, 8'h00); key(8'h12, 8'h00);
    key(8'h58, 8'h00); key(8'h1C, 8'h61);
    check("sc.count", 32'(count), 32'd2);
    check("sc.head0", 32'(data), 32'h2061);
    pop();
    check("sc.head1", 32'(data), 32'h0461);
    pop();
    key(8'h58, 8'h00);   // caps back off

    // Extended unmapped key, extended break, right ctrl
    key(8'hE0, 8'h00); key(8'h74, 8'h00);
    check("ext.make", 32'(data), 32'h4274);
    pop();
    key(8'hE0, 8'h00); key(8'hF0, 8'h00); key(8'h74, 8'h00);
    check("ext.brk", 32'(data), 32'hC274);
    pop();
    key(8'hE0, 8'h00); key(8'h14, 8'h00); key(8'h1C, 8'h61);
    check("ext.rctrl", 32'(data), 32'h1061);
    pop();
    key(8'hE0, 8'h00); key(8'hF0, 8'h00); key(8'h14, 8'h00);

    // Pause sequence and ignored bytes
    key(8'hE1, 8'h00); key(8'h14, 8'h00); key(8'h77, 8'h00); key(8'hE1, 8'h00);
    key(8'hF0, 8'h00); key(8'h14, 8'h00); key(8'hF0, 8'h00); key(8'h77, 8'h00);
    key(8'hAA, 8'h00); key(8'hFA, 8'h00);
    check("pause.count", 32'(count), 32'd0);
    key(8'h1C, 8'h61);
    check("pause.after", 32'(data), 32'h0061);
    pop();

    // Push during pop when full keeps count and leaves overflow clear
    for (int i = 0; i < 16; i++) key(8'h1C, 8'h61);
    step(1'b1, 8'h1C, 8'h61, 1'b1);
    check("full.pp.count", 32'(count), 32'd16);
    check("full.pp.ovf",   32'(overflow), 32'd0);
    key(8'h1C, 8'h61);
    check("full.drop.count", 32'(count), 32'd16);
    check("full.drop.ovf",   32'(overflow), 32'd1);
    check("full.drop.head",  32'(data), 32'h0061);
    pop();
    check("full.pop.ovf", 32'(overflow), 32'd0);

    // Reset mid-prefix discards stored entries and the pending break
    key(8'hF0, 8'h00);
    mid_reset();
    key(8'h1C, 8'h61);
    check("rst.mid.data",  32'(data), 32'h0061);
    check("rst.mid.count", 32'(count), 32'd1);
    check("rst.mid.ovf",   32'(overflow), 32'd0);

    // Random traffic, alternating drain-heavy and fill-heavy phases
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b, a;
      bit         v, r;
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 99) < 35) ? specials[$urandom_range(0, 12)]
                                       : 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      r = ((i / 400) % 2 == 0) ? ($urandom_range(0, 1) == 0)
                               : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) mid_reset();
      else step(v, b, a, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
